dmem_wait: RTL and testbench
============================

DMEM_WAIT -- requirements
Module: dmem_wait

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 256, number of words (power of two).
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, wait states between request accept and access (0..15).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  block can accept a request.
REQ-008 SHALL have port we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port a  input  32  byte address.
REQ-010 SHALL have port wd  input  DATA_W  write data.
REQ-011 SHALL have port be  input  DATA_W/8  byte write enables.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-014 SHALL have port rd  output  DATA_W  read data (0 for writes).
REQ-015 SHALL have port err  output  1  request was misaligned or out of range.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; request accepted on req_valid && req_ready, latching we, a, wd, be.
REQ-018 SHALL, on accept, load wait counter with WAIT_CYCLES and go to WAIT; if WAIT_CYCLES=0, go directly to RESP.
REQ-019 SHALL decrement counter each WAIT cycle; on the cycle counter equals 1, perform access and go to RESP.
REQ-020 SHALL give total latency accept-edge to rsp_valid=1 of WAIT_CYCLES+1 cycles.
REQ-021 SHALL, on write access, update only bytes whose be bit is 1 at word index a[..]/(DATA_W/8); be=0 writes nothing.
REQ-022 SHALL, on read access, register word into rd; rd=0 and err=0 for successful writes.
REQ-023 SHALL hold rsp_valid, rd, err stable in RESP until rsp_ready=1; on rsp_valid && rsp_ready go to IDLE, clear rsp_valid.
REQ-024 SHALL NOT accept a new request in the cycle the response is consumed (req_ready asserts next cycle).
REQ-025 SHALL ignore req_valid, we, a, wd, be outside IDLE.
REQ-026 SHALL make a read after a write to the same word return the written data (no stale read).

Reset
REQ-027 SHALL, on reset=1 at clock edge, set state IDLE, counter 0, rsp_valid 0, rd 0, err 0, req_ready 1 next cycle.
REQ-028 SHALL discard a request in WAIT on reset; its write SHALL NOT reach the array.
REQ-029 SHALL NOT reset memory contents.

Configuration
REQ-030 SHALL, with DMEM_ERR_CHECK_EN defined, flag err=1 when a is not word-aligned or word index >= DEPTH; write suppressed, rd=0, latency unchanged.
REQ-031 SHALL, without DMEM_ERR_CHECK_EN, tie err to 0, ignore low address bits, index modulo DEPTH.

Structure
REQ-032 SHALL place FSM state enum and WORD_BYTES (DATA_W/8) constant in shared package dmem_pkg.
REQ-033 SHALL instantiate one sub-module dmem_array: synchronous byte-enable storage, DEPTH x DATA_W.

Verification
REQ-034 SHALL cover: reset, write a=0x10 wd=0xDEADBEEF be=0xF, WAIT_CYCLES=2 -> rsp_valid at cycle 3 after accept, err=0; read 0x10 -> rd=0xDEADBEEF.
REQ-035 SHALL cover: write a=0x10 wd=0x000000AA be=0x1 over 0xDEADBEEF -> read returns 0xDEADBEAA.
REQ-036 SHALL cover: read completes with rsp_ready=0 for 5 cycles -> rsp_valid, rd stable, req_ready=0 throughout, single consume.
REQ-037 SHALL cover: DMEM_ERR_CHECK_EN, write a=0x12 -> err=1, subsequent read 0x10 unchanged; a=DEPTH*4 -> err=1.
REQ-038 SHALL cover: write a=0x20 wd=0x12345678, reset asserted in WAIT -> read 0x20 returns prior value, not 0x12345678.
REQ-039 SHALL cover: WAIT_CYCLES=0 build -> rsp_valid one cycle after accept; back-to-back requests at one per 3 cycles with rsp_ready=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-state data memory: FSM state type,
// default word geometry and a small width helper.
package dmem_pkg;

    // Request lifecycle: accept in IDLE, count wait states, hold the response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Default data width and the matching number of bytes per word.
    localparam int DEF_DATA_W = 32;
    localparam int WORD_BYTES = DEF_DATA_W / 8;

    // Width of the wait-state counter; it holds 0..15.
    localparam int CNT_W = 4;

    // Bytes per word for an arbitrary data width.
    function automatic int wordBytes(input int dataW);
        return dataW / 8;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous DEPTH x DATA_W storage with per-byte write enables.
// A read updates the output register only when a read is issued, so the
// output holds its value while the owner waits for the response handshake.
// The contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 256,
    localparam int WB    = wordBytes(DATA_W),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_idx,
    input  logic [DATA_W-1:0] i_wd,
    input  logic [WB-1:0]     i_be,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    // Write only the byte lanes whose enable bit is set.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            for (int b = 0; b < WB; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wd[8*b +: 8];
                end
            end
        end
    end

    // Capture the addressed word on a read and keep it until the next read.
    always_ff @(posedge clk) begin
        if (i_en && !i_we) begin
            r_q <= r_mem[i_idx];
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dmem_wait.sv
// Data memory with a fixed number of wait states between accepting a request
// and performing the access, plus a valid/ready response channel.
// Optional feature macro: DMEM_ERR_CHECK_EN -- flags misaligned or
// out-of-range addresses (write suppressed, rd forced to 0). Without it the
// low address bits are ignored and the word index wraps modulo DEPTH.
module dmem_wait
    import dmem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     we,
    input  logic [31:0]              a,
    input  logic [DATA_W-1:0]        wd,
    input  logic [DATA_W/8-1:0]      be,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rd,
    output logic                     err
);

    localparam int WB = wordBytes(DATA_W);
    localparam int OB = (WB > 1) ? $clog2(WB) : 0;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dmem_state_t       r_state;
    dmem_state_t       w_next;
    logic [CNT_W-1:0]  r_count;

    logic              r_we;
    logic [31:0]       r_a;
    logic [DATA_W-1:0] r_wd;
    logic [WB-1:0]     r_be;

    logic              r_err;
    logic              r_rdSel;

    logic              w_accept;
    logic              w_access;
    logic              w_inIdle;
    logic              w_accWe;
    logic [31:0]       w_accA;
    logic [DATA_W-1:0] w_accWd;
    logic [WB-1:0]     w_accBe;
    logic [31:0]       w_wordIdx;
    logic [AW-1:0]     w_idx;
    logic              w_err;
    logic              w_memEn;
    logic [DATA_W-1:0] w_q;
    logic              w_unused;

    assign w_inIdle = (r_state == IDLE);
    assign w_accept = w_inIdle && req_valid;

    // With zero wait states the access happens on the accept edge itself, so
    // the access operands come straight from the inputs while in IDLE and
    // from the latched request otherwise.
    assign w_accWe   = w_inIdle ? we : r_we;
    assign w_accA    = w_inIdle ? a  : r_a;
    assign w_accWd   = w_inIdle ? wd : r_wd;
    assign w_accBe   = w_inIdle ? be : r_be;
    assign w_wordIdx = w_accA >> OB;
    assign w_idx     = w_wordIdx[AW-1:0];

`ifdef DMEM_ERR_CHECK_EN
    assign w_err = ((w_accA & 32'(WB - 1)) != 32'd0) || (w_wordIdx >= 32'(DEPTH));
`else
    assign w_err = 1'b0;
`endif

    assign w_unused = ^w_wordIdx;

    // A reset on the access edge cancels the access, so a request caught in
    // WAIT never reaches the array.
    assign w_memEn = w_access && !reset && !w_err;

    // Next-state logic and the strobe that marks the access cycle.
    always_comb begin
        w_next   = r_state;
        w_access = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next   = RESP;
                        w_access = 1'b1;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_count <= CNT_W'(1)) begin
                    w_next   = RESP;
                    w_access = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Wait-state counter: loaded on accept, counts down while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= CNT_W'(WAIT_CYCLES);
        end else if ((r_state == WAIT) && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Hold the accepted request for the access that happens later.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we <= we;
            r_a  <= a;
            r_wd <= wd;
            r_be <= be;
        end
    end

    // Response flags: err and whether rd shows the array output, set on the
    // access edge and cleared when the response is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err   <= 1'b0;
            r_rdSel <= 1'b0;
        end else if (w_access) begin
            r_err   <= w_err;
            r_rdSel <= !w_accWe && !w_err;
        end else if ((r_state == RESP) && rsp_ready) begin
            r_err   <= 1'b0;
            r_rdSel <= 1'b0;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .i_en  (w_memEn),
        .i_we  (w_accWe),
        .i_idx (w_idx),
        .i_wd  (w_accWd),
        .i_be  (w_accBe),
        .o_q   (w_q)
    );

    assign req_ready = w_inIdle;
    assign rsp_valid = (r_state == RESP);
    assign rd        = r_rdSel ? w_q : '0;
    assign err       = r_err;

endmodule

// File: tb/tb_dmem_wait.sv
// Bench for dmem_wait: two instances share one stimulus stream, one with two
// wait states and one with none. A transaction-level model predicts both.
module tb_dmem_wait;
   import dmem_pkg::*;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        we = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] wd = 32'd0;
   logic [3:0]  be = 4'd0;
   logic        rsp_ready = 1'b1;

   logic        reqReadyA, rspValidA, errA;
   logic        reqReadyB, rspValidB, errB;
   logic [31:0] rdA, rdB;

   int total = 0;
   int bad = 0;
   bit chkEn = 1'b0;

   // Model state, index 0 = two wait states, index 1 = none
   logic [31:0] mMem [2][DEPTH];
   bit          mBusy [2];
   int          mCnt [2];
   logic        mWe [2];
   logic [31:0] mA [2];
   logic [31:0] mWd [2];
   logic [3:0]  mBe [2];
   logic [31:0] mRd [2];
   logic        mErr [2];

   dmem_wait #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dutA (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(reqReadyA),
      .we(we), .a(a), .wd(wd), .be(be), .rsp_valid(rspValidA),
      .rsp_ready(rsp_ready), .rd(rdA), .err(errA)
   );

   dmem_wait #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dutB (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(reqReadyB),
      .we(we), .a(a), .wd(wd), .be(be), .rsp_valid(rspValidB),
      .rsp_ready(rsp_ready), .rd(rdB), .err(errB)
   );

   // Free-running clock
   always #5 clk = ~clk;

   function automatic int latOf(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic bit expValid(input int d);
      return mBusy[d] && (mCnt[d] >= latOf(d) + 1);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=%b required=%b", name, act, exp);
      end
   endtask

   // Resolve a transaction against the model memory when its access is due
   task automatic modelCommit(input int d);
      logic [31:0] widx;
      widx = mA[d] >> 2;
`ifdef DMEM_ERR_CHECK_EN
      mErr[d] = (mA[d][1:0] != 2'd0) || (widx >= 32'(DEPTH));
`else
      mErr[d] = 1'b0;
      widx = widx % 32'(DEPTH);
`endif
      mRd[d] = 32'd0;
      if (!mErr[d]) begin
         if (mWe[d]) begin
            for (int b = 0; b < 4; b++)
               if (mBe[d][b]) mMem[d][widx[7:0]][8*b +: 8] = mWd[d][8*b +: 8];
         end else begin
            mRd[d] = mMem[d][widx[7:0]];
         end
      end
   endtask

   // Advance the model by one clock: cycles since accept decide visibility
   task automatic modelStep(input int d);
      if (reset) begin
         mBusy[d] = 1'b0;
         mCnt[d] = 0;
      end else if (!mBusy[d]) begin
         if (req_valid) begin
            mBusy[d] = 1'b1;
            mCnt[d] = 1;
            mWe[d] = we; mA[d] = a; mWd[d] = wd; mBe[d] = be;
            if (latOf(d) == 0) modelCommit(d);
         end
      end else if (mCnt[d] >= latOf(d) + 1) begin
         if (rsp_ready) mBusy[d] = 1'b0;
      end else begin
         mCnt[d]++;
         if (mCnt[d] == latOf(d) + 1) modelCommit(d);
      end
   endtask

   // Model update on every rising edge
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) modelStep(d);
   end

   // Compare both DUTs against the model away from the active edge
   always @(negedge clk) begin
      if (chkEn) begin
         for (int d = 0; d < 2; d++) begin
            checkBit($sformatf("req_ready dut%0d", d), (d == 0) ? reqReadyA : reqReadyB, !mBusy[d]);
            checkBit($sformatf("rsp_valid dut%0d", d), (d == 0) ? rspValidA : rspValidB, expValid(d));
            if (expValid(d)) begin
               checkOutput($sformatf("rd dut%0d", d), (d == 0) ? rdA : rdB, mRd[d]);
               checkBit($sformatf("err dut%0d", d), (d == 0) ? errA : errB, mErr[d]);
            end
         end
      end
   end

   // Present one request for a single clock; returns at the next falling edge
   task automatic applyStimulus(input logic iWe, input logic [31:0] iA,
                                input logic [31:0] iWd, input logic [3:0] iBe);
      req_valid = 1'b1;
      we = iWe; a = iA; wd = iWd; be = iBe;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Count cycles from accept until the two-wait-state instance responds
   task automatic waitResp(output int lat);
      lat = 1;
      while (!rspValidA && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!rspValidA) begin
         total++;
         bad++;
         $display("[TB] FAIL response timeout: actual=no rsp_valid required=rsp_valid");
      end
   endtask

   task automatic doTxn(input logic iWe, input logic [31:0] iA, input logic [31:0] iWd,
                        input logic [3:0] iBe, output int lat,
                        output logic [31:0] rdv, output logic errv);
      applyStimulus(iWe, iA, iWd, iBe);
      waitResp(lat);
      rdv = rdA;
      errv = errA;
      @(negedge clk);
   endtask

   initial begin
      int lat;
      logic [31:0] rdv;
      logic errv;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chkEn = 1'b1;
      reset = 1'b0;
      checkBit("reset req_ready", reqReadyA, 1'b1);
      checkBit("reset rsp_valid", rspValidA, 1'b0);
      checkOutput("reset rd", rdA, 32'd0);
      checkBit("reset err", errA, 1'b0);

      doTxn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rdv, errv);
      checkOutput("write latency", 32'(lat), 32'd3);
      checkOutput("write rd", rdv, 32'd0);
      checkBit("write err", errv, 1'b0);

      doTxn(1'b0, 32'h10, 32'd0, 4'h0, lat, rdv, errv);
      checkOutput("read latency", 32'(lat), 32'd3);
      checkOutput("read 0x10", rdv, 32'hDEADBEEF);

      doTxn(1'b1, 32'h10, 32'h000000AA, 4'h1, lat, rdv, errv);
      doTxn(1'b0, 32'h10, 32'd0, 4'h0, lat, rdv, errv);
      checkOutput("byte merge", rdv, 32'hDEADBEAA);

      doTxn(1'b1, 32'h14, 32'h11223344, 4'hF, lat, rdv, errv);
      doTxn(1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, lat, rdv, errv);
      doTxn(1'b0, 32'h14, 32'd0, 4'h0, lat, rdv, errv);
      checkOutput("be zero", rdv, 32'h11223344);

      rsp_ready = 1'b0;
      applyStimulus(1'b0, 32'h10, 32'd0, 4'h0);
      waitResp(lat);
      checkOutput("stall latency", 32'(lat), 32'd3);
      for (int i = 0; i < 5; i++) begin
         checkBit("stall rsp_valid", rspValidA, 1'b1);
         checkOutput("stall rd", rdA, 32'hDEADBEAA);
         checkBit("stall req_ready", reqReadyA, 1'b0);
         req_valid = 1'b1; we = 1'b1; a = 32'h10; wd = 32'h0; be = 4'hF;
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      checkBit("consume rsp_valid", rspValidA, 1'b0);
      checkBit("consume req_ready", reqReadyA, 1'b1);
      doTxn(1'b0, 32'h10, 32'd0, 4'h0, lat, rdv, errv);
      checkOutput("ignored write", rdv, 32'hDEADBEAA);

      doTxn(1'b1, 32'h20, 32'h0BADF00D, 4'hF, lat, rdv, errv);
      applyStimulus(1'b1, 32'h20, 32'h12345678, 4'hF);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkBit("wait reset req_ready", reqReadyA, 1'b1);
      checkBit("wait reset rsp_valid", rspValidA, 1'b0);
      doTxn(1'b0, 32'h20, 32'd0, 4'h0, lat, rdv, errv);
      checkOutput("discarded write", rdv, 32'h0BADF00D);

`ifdef DMEM_ERR_CHECK_EN
      doTxn(1'b1, 32'h12, 32'h0, 4'hF, lat, rdv, errv);
      checkBit("misaligned err", errv, 1'b1);
      checkOutput("misaligned latency", 32'(lat), 32'd3);
      doTxn(1'b0, 32'h10, 32'd0, 4'h0, lat, rdv, errv);
      checkOutput("after misaligned", rdv, 32'hDEADBEAA);
      checkBit("aligned err", errv, 1'b0);
      doTxn(1'b0, 32'(DEPTH * 4), 32'd0, 4'h0, lat, rdv, errv);
      checkBit("range err", errv, 1'b1);
      checkOutput("range rd", rdv, 32'd0);
      doTxn(1'b1, 32'(DEPTH * 4), 32'h55555555, 4'hF, lat, rdv, errv);
      doTxn(1'b0, 32'h0, 32'd0, 4'h0, lat, rdv, errv);
      checkBit("word0 err", errv, 1'b0);
`else
      doTxn(1'b1, 32'h10 + 32'(DEPTH * 4), 32'hCAFEF00D, 4'hF, lat, rdv, errv);
      checkBit("wrap err", errv, 1'b0);
      doTxn(1'b0, 32'h13, 32'd0, 4'h0, lat, rdv, errv);
      checkOutput("wrap read", rdv, 32'hCAFEF00D);
      checkBit("low bits err", errv, 1'b0);
`endif

      for (int i = 0; i < 8; i++) begin
         if (i == 4) applyStimulus(1'b1, 32'h10, 32'h600DCAFE, 4'hF);
         else applyStimulus(1'b0, (i % 2 == 1) ? 32'h20 : 32'h10, 32'd0, 4'h0);
         checkBit("zero-wait latency", rspValidB, 1'b1);
         @(negedge clk);
         checkBit("zero-wait consumed", rspValidB, 1'b0);
         checkBit("zero-wait req_ready", reqReadyB, 1'b1);
         @(negedge clk);
      end

      repeat (10) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
